// File: rtl/serial_sub_arbiter.sv
// Two-requester round-robin arbiter in front of a bit-serial subtractor.
// The winner's operands are shifted LSB first through a one-bit borrow chain.
module serial_sub_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             done_id
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, GRANT, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [CW-1:0]    cnt;
   logic             borrow_ff;
   logic             last_served;
   logic             cur_id;

   logic pick1;
   logic d_bit;
   logic bout;

   // Requester 1 wins when alone, or on a tie when requester 0 was served last.
   assign pick1 = req1 & (~req0 | ~last_served);

   assign d_bit = a_sr[0] ^ b_sr[0] ^ borrow_ff;
   assign bout  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow_ff);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_sr        <= '0;
         b_sr        <= '0;
         res_sr      <= '0;
         cnt         <= '0;
         borrow_ff   <= 1'b0;
         last_served <= 1'b1;
         cur_id      <= 1'b0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         diff        <= '0;
         borrow_out  <= 1'b0;
         done_id     <= 1'b0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  a_sr        <= pick1 ? a1 : a0;
                  b_sr        <= pick1 ? b1 : b0;
                  cur_id      <= pick1;
                  last_served <= pick1;
                  gnt0        <= ~pick1;
                  gnt1        <= pick1;
                  borrow_ff   <= 1'b0;
                  cnt         <= '0;
                  busy        <= 1'b1;
                  state       <= GRANT;
               end
            end
            GRANT: begin
               state <= SHIFT;
            end
            SHIFT: begin
               a_sr      <= a_sr >> 1;
               b_sr      <= b_sr >> 1;
               res_sr    <= {d_bit, res_sr[WIDTH-1:1]};
               borrow_ff <= bout;
               cnt       <= cnt + 1'b1;
               // The final bit goes straight into diff so the result lands on DONE entry.
               if (cnt == CNT_LAST) begin
                  cnt        <= '0;
                  diff       <= {d_bit, res_sr[WIDTH-1:1]};
                  borrow_out <= bout;
                  done_id    <= cur_id;
                  done       <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_arbiter.sv
// Directed bench for serial_sub_arbiter at WIDTH=8: arithmetic corners,
// round-robin fairness, request blocking while busy, operand capture and reset abort.
module tb_serial_sub_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0, req1;
   logic [7:0] a0, b0, a1, b1;
   logic       gnt0, gnt1, busy, done;
   logic [7:0] diff;
   logic       borrow_out, done_id;

   int vectors;
   int miscompares;

   serial_sub_arbiter #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
      .diff(diff), .borrow_out(borrow_out), .done_id(done_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Grants must be exclusive and never coincide with done.
   always @(negedge clk) begin
      if (rst_n) begin
         vectors++;
         if ((gnt0 && gnt1) || (done && (gnt0 || gnt1))) begin
            miscompares++;
            $display("FAIL exclusivity: gnt0=%0b gnt1=%0b done=%0b required no overlap", gnt0, gnt1, done);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Returns negedges waited until a grant is visible, or -1 on timeout.
   task automatic wait_gnt(output int cyc);
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (gnt0 || gnt1) break;
         if (cyc > 30) begin cyc = -1; break; end
      end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (done) break;
         if (cyc > 30) begin cyc = -1; break; end
      end
   endtask

   task automatic test_reset();
      #3;
      vectors++;
      if ({gnt0, gnt1, busy, done, borrow_out, done_id, diff} !== 14'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got gnt0=%0b gnt1=%0b busy=%0b done=%0b bo=%0b id=%0b diff=%h required all 0",
                  gnt0, gnt1, busy, done, borrow_out, done_id, diff);
      end
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset released");
   endtask

   task automatic test_basic();
      logic [7:0] ta [4];
      logic [7:0] tb [4];
      logic [7:0] td [4];
      logic       tbo[4];
      int c;
      ta[0] = 8'h35; tb[0] = 8'h12; td[0] = 8'h23; tbo[0] = 1'b0;
      ta[1] = 8'h12; tb[1] = 8'h35; td[1] = 8'hDD; tbo[1] = 1'b1;
      ta[2] = 8'h00; tb[2] = 8'h01; td[2] = 8'hFF; tbo[2] = 1'b1;
      ta[3] = 8'hFF; tb[3] = 8'hFF; td[3] = 8'h00; tbo[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a0 = ta[i]; b0 = tb[i]; req0 = 1'b1;
         wait_gnt(c);
         vectors++;
         if (!(gnt0 === 1'b1 && gnt1 === 1'b0 && busy === 1'b1)) begin
            miscompares++;
            $display("FAIL basic_gnt[%0d]: gnt0=%0b gnt1=%0b busy=%0b required 1 0 1", i, gnt0, gnt1, busy);
         end
         req0 = 1'b0;
         wait_done(c);
         vectors++;
         if (c !== 9) begin
            miscompares++;
            $display("FAIL basic_latency[%0d]: got %0d cycles required 9", i, c);
         end
         vectors++;
         if (diff !== td[i] || borrow_out !== tbo[i] || done_id !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result[%0d]: got diff=%h bo=%0b id=%0b required diff=%h bo=%0b id=0",
                     i, diff, borrow_out, done_id, td[i], tbo[i]);
         end
         $display("op req0 a=%h b=%h -> diff=%h borrow=%0b id=%0b", ta[i], tb[i], diff, borrow_out, done_id);
         @(negedge clk);
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0 || diff !== td[i]) begin
            miscompares++;
            $display("FAIL basic_hold[%0d]: done=%0b busy=%0b diff=%h required 0 0 %h", i, done, busy, diff, td[i]);
         end
      end
   endtask

   task automatic test_round_robin();
      int c;
      logic exp_id;
      logic [7:0] exp_d;
      logic       exp_bo;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      a0 = 8'h50; b0 = 8'h10;
      a1 = 8'h20; b1 = 8'h30;
      req0 = 1'b1; req1 = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_id = i[0];
         exp_d  = exp_id ? 8'hF0 : 8'h40;
         exp_bo = exp_id;
         wait_gnt(c);
         vectors++;
         if (gnt0 !== ~exp_id || gnt1 !== exp_id) begin
            miscompares++;
            $display("FAIL rr_gnt[%0d]: gnt0=%0b gnt1=%0b required requester %0d", i, gnt0, gnt1, exp_id);
         end
         wait_done(c);
         vectors++;
         if (c !== 9 || done_id !== exp_id || diff !== exp_d || borrow_out !== exp_bo) begin
            miscompares++;
            $display("FAIL rr_result[%0d]: lat=%0d id=%0b diff=%h bo=%0b required 9 %0b %h %0b",
                     i, c, done_id, diff, borrow_out, exp_id, exp_d, exp_bo);
         end
         $display("op rr%0d id=%0b diff=%h borrow=%0b", i, done_id, diff, borrow_out);
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_operand_change();
      int c;
      a0 = 8'h35; b0 = 8'h12; req0 = 1'b1;
      wait_gnt(c);
      a0 = 8'hFF; b0 = 8'h00; req0 = 1'b0;
      @(negedge clk);
      a0 = 8'h01; b0 = 8'h80;
      wait_done(c);
      vectors++;
      if (diff !== 8'h23 || borrow_out !== 1'b0 || done_id !== 1'b0) begin
         miscompares++;
         $display("FAIL capture: got diff=%h bo=%0b id=%0b required 23 0 0", diff, borrow_out, done_id);
      end
      $display("op capture diff=%h borrow=%0b", diff, borrow_out);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int c;
      logic early;
      a0 = 8'h60; b0 = 8'h21; req0 = 1'b1;
      wait_gnt(c);
      req0 = 1'b0;
      repeat (3) @(negedge clk);
      a1 = 8'h09; b1 = 8'h04; req1 = 1'b1;
      early = 1'b0;
      c = 0;
      while (!done && c < 30) begin
         @(negedge clk);
         c++;
         if (gnt1) early = 1'b1;
      end
      vectors++;
      if (early !== 1'b0 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_blocked: early_gnt1=%0b done=%0b required 0 1", early, done);
      end
      vectors++;
      if (diff !== 8'h3F || done_id !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_first: diff=%h id=%0b required 3f 0", diff, done_id);
      end
      @(negedge clk);
      vectors++;
      if (gnt1 !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_idle: gnt1=%0b busy=%0b required 0 0", gnt1, busy);
      end
      @(negedge clk);
      vectors++;
      if (gnt1 !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_gnt1: gnt1=%0b required 1", gnt1);
      end
      req1 = 1'b0;
      wait_done(c);
      vectors++;
      if (c !== 9 || diff !== 8'h05 || borrow_out !== 1'b0 || done_id !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_second: lat=%0d diff=%h bo=%0b id=%0b required 9 05 0 1", c, diff, borrow_out, done_id);
      end
      $display("op b2b id=%0b diff=%h borrow=%0b", done_id, diff, borrow_out);
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int c;
      int dones;
      a0 = 8'h44; b0 = 8'h11; req0 = 1'b1;
      wait_gnt(c);
      req0 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({gnt0, gnt1, busy, done, borrow_out, done_id, diff} !== 14'h0) begin
         miscompares++;
         $display("FAIL abort_outputs: gnt0=%0b gnt1=%0b busy=%0b done=%0b bo=%0b id=%0b diff=%h required all 0",
                  gnt0, gnt1, busy, done, borrow_out, done_id, diff);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) dones++;
      end
      vectors++;
      if (dones !== 0) begin
         miscompares++;
         $display("FAIL abort_no_done: saw %0d done pulses required 0", dones);
      end
      a0 = 8'h80; b0 = 8'h01; req0 = 1'b1;
      wait_gnt(c);
      vectors++;
      if (gnt0 !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_regrant: gnt0=%0b required 1", gnt0);
      end
      req0 = 1'b0;
      wait_done(c);
      vectors++;
      if (c !== 9 || diff !== 8'h7F || borrow_out !== 1'b0 || done_id !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_fresh: lat=%0d diff=%h bo=%0b id=%0b required 9 7f 0 0", c, diff, borrow_out, done_id);
      end
      $display("op post-reset diff=%h borrow=%0b", diff, borrow_out);
      @(negedge clk);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      test_reset();
      test_basic();
      test_round_robin();
      test_operand_change();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
